// File: rtl/melee_attack_ctrl.sv
// Melee swing sequencer: click -> wind-up, strike, recover, cooldown, with one damage pulse per swing.
// Optional feature: define MELEE_AUTO_REPEAT_EN to chain swings while the button stays held.
module melee_attack_ctrl #(
  parameter int WINDUP_FRAMES   = 2,
  parameter int STRIKE_FRAMES   = 4,
  parameter int RECOVER_FRAMES  = 2,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int OFFSET_STEP     = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick_i,
  input  logic        attack_req_i,
  input  logic [1:0]  game_active_i,
  input  logic [1:0]  char_class_i,
  input  logic        alive_i,
  input  logic        flip_hor_i,
  input  logic        melee_hit_i,
  output logic        swing_active_o,
  output logic        swing_flip_o,
  output logic [11:0] anim_x_offset_o,
  output logic        damage_pulse_o,
  output logic        attack_busy_o
);

  // state    | meaning
  // IDLE     | weapon hidden, waiting for a click
  // WINDUP   | weapon visible at rest, offset 0
  // STRIKE   | offset grows each frame, hits honoured
  // RECOVER  | offset shrinks back toward 0
  // COOLDOWN | weapon hidden, new clicks ignored
  typedef enum logic [2:0] {
    S_IDLE,
    S_WINDUP,
    S_STRIKE,
    S_RECOVER,
    S_COOLDOWN
  } state_t;

  localparam logic [11:0] STEP          = 12'(OFFSET_STEP);
  localparam logic [11:0] RET_STEP      = 12'((STRIKE_FRAMES * OFFSET_STEP) / RECOVER_FRAMES);
  localparam logic [7:0]  WINDUP_LAST   = 8'(WINDUP_FRAMES - 1);
  localparam logic [7:0]  STRIKE_LAST   = 8'(STRIKE_FRAMES - 1);
  localparam logic [7:0]  RECOVER_LAST  = 8'(RECOVER_FRAMES - 1);
  localparam logic [7:0]  COOLDOWN_LAST = 8'(COOLDOWN_FRAMES - 1);

  state_t      state_q, state_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [11:0] offset_q, offset_d;
  logic        hit_q, hit_d;
  logic        flip_q, flip_d;
  logic        pulse_d;
  logic        req_q, req_prev_q, arm_q;
  logic        swing_active_q, attack_busy_q, damage_pulse_q;

  logic        en;
  logic        start_edge;
  logic [7:0]  frame_lim;
  logic        last_tick;

  assign en = (game_active_i != 2'd0) && alive_i && (char_class_i == 2'd1);
  // arm_q blocks a button held through reset from looking like a fresh click
  assign start_edge = req_q && !req_prev_q && arm_q;

  always_comb begin
    frame_lim = 8'd0;
    case (state_q)
      S_WINDUP:   frame_lim = WINDUP_LAST;
      S_STRIKE:   frame_lim = STRIKE_LAST;
      S_RECOVER:  frame_lim = RECOVER_LAST;
      S_COOLDOWN: frame_lim = COOLDOWN_LAST;
      default:    frame_lim = 8'd0;
    endcase
  end

  assign last_tick = frame_tick_i && (frame_cnt_q == frame_lim);

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    offset_d    = offset_q;
    hit_d       = hit_q;
    flip_d      = flip_q;
    pulse_d     = 1'b0;
    if (!en) begin
      state_d     = S_IDLE;
      frame_cnt_d = 8'd0;
      offset_d    = 12'd0;
      hit_d       = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            state_d     = S_WINDUP;
            frame_cnt_d = 8'd0;
            offset_d    = 12'd0;
            hit_d       = 1'b0;
            flip_d      = flip_hor_i;
          end
        end
        S_WINDUP: begin
          if (last_tick) begin
            state_d     = S_STRIKE;
            frame_cnt_d = 8'd0;
          end else if (frame_tick_i) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
        S_STRIKE: begin
          if (melee_hit_i && !hit_q) begin
            hit_d   = 1'b1;
            pulse_d = 1'b1;
          end
          if (frame_tick_i) begin
            offset_d = offset_q + STEP;
            if (last_tick) begin
              state_d     = S_RECOVER;
              frame_cnt_d = 8'd0;
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end
        end
        S_RECOVER: begin
          if (last_tick) begin
            state_d     = S_COOLDOWN;
            frame_cnt_d = 8'd0;
            offset_d    = 12'd0;
          end else if (frame_tick_i) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            offset_d    = (offset_q > RET_STEP) ? (offset_q - RET_STEP) : 12'd0;
          end
        end
        S_COOLDOWN: begin
          if (last_tick) begin
            frame_cnt_d = 8'd0;
`ifdef MELEE_AUTO_REPEAT_EN
            if (req_q) begin
              state_d = S_WINDUP;
              hit_d   = 1'b0;
              flip_d  = flip_hor_i;
            end else begin
              state_d = S_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
          end else if (frame_tick_i) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
        default: begin
          state_d     = S_IDLE;
          frame_cnt_d = 8'd0;
          offset_d    = 12'd0;
          hit_d       = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      frame_cnt_q    <= 8'd0;
      offset_q       <= 12'd0;
      hit_q          <= 1'b0;
      flip_q         <= 1'b0;
      req_q          <= 1'b0;
      req_prev_q     <= 1'b0;
      arm_q          <= 1'b0;
      swing_active_q <= 1'b0;
      attack_busy_q  <= 1'b0;
      damage_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      offset_q       <= offset_d;
      hit_q          <= hit_d;
      flip_q         <= flip_d;
      req_q          <= attack_req_i;
      req_prev_q     <= req_q;
      arm_q          <= arm_q | ~attack_req_i;
      swing_active_q <= (state_d == S_WINDUP) || (state_d == S_STRIKE) || (state_d == S_RECOVER);
      attack_busy_q  <= (state_d != S_IDLE);
      damage_pulse_q <= pulse_d;
    end
  end

  assign swing_active_o  = swing_active_q;
  assign swing_flip_o    = flip_q;
  assign anim_x_offset_o = offset_q;
  assign damage_pulse_o  = damage_pulse_q;
  assign attack_busy_o   = attack_busy_q;

endmodule

// File: tb/tb_melee_attack_ctrl.sv
// Scoreboard bench for melee_attack_ctrl: expected output snapshots are queued ahead of stimulus
// and a negedge monitor pops one for every change on the DUT outputs.
module tb_melee_attack_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick, attack_req, alive, flip_hor, melee_hit;
  logic [1:0]  game_active, char_class;
  logic        swing_active, swing_flip, damage_pulse, attack_busy;
  logic [11:0] anim_x_offset;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  melee_attack_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick_i    (frame_tick),
    .attack_req_i    (attack_req),
    .game_active_i   (game_active),
    .char_class_i    (char_class),
    .alive_i         (alive),
    .flip_hor_i      (flip_hor),
    .melee_hit_i     (melee_hit),
    .swing_active_o  (swing_active),
    .swing_flip_o    (swing_flip),
    .anim_x_offset_o (anim_x_offset),
    .damage_pulse_o  (damage_pulse),
    .attack_busy_o   (attack_busy)
  );

  // snapshot layout: {busy, active, flip, pulse, offset[11:0]}
  function automatic logic [15:0] snap(logic b, logic a, logic f, logic p, logic [11:0] o);
    return {b, a, f, p, o};
  endfunction

  function automatic logic [15:0] dut_snap();
    return snap(attack_busy, swing_active, swing_flip, damage_pulse, anim_x_offset);
  endfunction

  task automatic push(logic b, logic a, logic f, logic p, int o);
    exp_q.push_back(snap(b, a, f, p, 12'(o)));
  endtask

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_gap();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(9);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick_gap();
  endtask

  initial begin : monitor
    logic [15:0] prev, cur, e;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = dut_snap();
      if (mon_en && (cur != prev)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard unexpected output: got %h, expected no change from %h", cur, prev);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL scoreboard: got %h, expected %h", cur, e);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin : stimulus
    logic [15:0] e;
    rst = 1'b1; attack_req = 1'b1; frame_tick = 1'b0; melee_hit = 1'b0;
    game_active = 2'd1; char_class = 2'd1; alive = 1'b1; flip_hor = 1'b0;
    step(3);
    chk("reset_outputs", dut_snap(), 16'h0000);
    rst = 1'b0;
    mon_en = 1'b1;
    step(5);
    tick_gap();
    chk("held_through_reset_no_swing", {15'd0, attack_busy}, 16'h0000);
    attack_req = 1'b0;
    step(3);

    // nominal swing, button held for the whole swing
    push(1, 1, 0, 0, 0);
    push(1, 1, 0, 0, 6);
    push(1, 1, 0, 0, 12);
    push(1, 1, 0, 0, 18);
    push(1, 1, 0, 0, 24);
    push(1, 1, 0, 0, 12);
    push(1, 0, 0, 0, 0);
`ifdef MELEE_AUTO_REPEAT_EN
    push(1, 1, 0, 0, 0);
    push(0, 0, 0, 0, 0);
`else
    push(0, 0, 0, 0, 0);
`endif
    attack_req = 1'b1;
    step(1);
    chk("start_latency_edge1", {15'd0, attack_busy}, 16'h0000);
    step(1);
    chk("start_latency_edge2", {14'd0, attack_busy, swing_active}, 16'h0003);
    ticks(6);
    chk("peak_offset", {4'd0, anim_x_offset}, 16'd24);
    ticks(2);
    chk("recover_exit", {14'd0, attack_busy, swing_active}, 16'h0002);
    ticks(8);
`ifdef MELEE_AUTO_REPEAT_EN
    chk("cooldown_exit_repeat", {14'd0, attack_busy, swing_active}, 16'h0003);
    attack_req = 1'b0;
    alive = 1'b0;
    step(1);
    alive = 1'b1;
`else
    chk("cooldown_exit_idle", {14'd0, attack_busy, swing_active}, 16'h0000);
    step(20);
    ticks(2);
    attack_req = 1'b0;
`endif
    step(3);

    // multi-hit swing, facing left, flip toggled and clicks issued mid-swing
    flip_hor = 1'b1;
    push(1, 1, 1, 0, 0);
    push(1, 1, 1, 1, 0);
    push(1, 1, 1, 0, 0);
    push(1, 1, 1, 0, 6);
    push(1, 1, 1, 0, 12);
    push(1, 1, 1, 0, 18);
    push(1, 1, 1, 0, 24);
    push(1, 1, 1, 0, 12);
    push(1, 0, 1, 0, 0);
    push(0, 0, 1, 0, 0);
    attack_req = 1'b1;
    step(2);
    attack_req = 1'b0;
    melee_hit = 1'b1;
    step(1);
    melee_hit = 1'b0;
    ticks(2);
    melee_hit = 1'b1;
    step(5);
    melee_hit = 1'b0;
    flip_hor = 1'b0;
    attack_req = 1'b1;
    step(2);
    attack_req = 1'b0;
    ticks(4);
    melee_hit = 1'b1;
    step(1);
    melee_hit = 1'b0;
    ticks(7);
    attack_req = 1'b1;
    step(2);
    attack_req = 1'b0;
    ticks(5);
    step(30);
    chk("no_queued_click", {15'd0, attack_busy}, 16'h0000);

    // hit coinciding with the STRIKE exit tick, then class change aborts RECOVER
    push(1, 1, 0, 0, 0);
    push(1, 1, 0, 0, 6);
    push(1, 1, 0, 0, 12);
    push(1, 1, 0, 0, 18);
    push(1, 1, 0, 1, 24);
    push(1, 1, 0, 0, 24);
    push(0, 0, 0, 0, 0);
    attack_req = 1'b1;
    step(2);
    attack_req = 1'b0;
    ticks(5);
    frame_tick = 1'b1;
    melee_hit = 1'b1;
    step(1);
    frame_tick = 1'b0;
    melee_hit = 1'b0;
    chk("exit_tick_hit_pulse", {15'd0, damage_pulse}, 16'h0001);
    step(4);
    char_class = 2'd2;
    step(2);
    char_class = 2'd1;
    step(3);

    // abort mid-STRIKE at offset 12, fresh swing, then abort with a coinciding tick
    push(1, 1, 0, 0, 0);
    push(1, 1, 0, 0, 6);
    push(1, 1, 0, 0, 12);
    push(0, 0, 0, 0, 0);
    push(1, 1, 0, 0, 0);
    push(0, 0, 0, 0, 0);
    attack_req = 1'b1;
    step(2);
    attack_req = 1'b0;
    ticks(4);
    alive = 1'b0;
    step(1);
    chk("abort_outputs", dut_snap(), 16'h0000);
    step(2);
    alive = 1'b1;
    step(1);
    attack_req = 1'b1;
    step(2);
    chk("restart_after_abort", {14'd0, attack_busy, swing_active}, 16'h0003);
    attack_req = 1'b0;
    step(3);
    tick_gap();
    game_active = 2'd0;
    frame_tick = 1'b1;
    step(1);
    game_active = 2'd1;
    frame_tick = 1'b0;
    chk("abort_beats_tick", dut_snap(), 16'h0000);

    // wrong class cannot start a swing
    char_class = 2'd2;
    attack_req = 1'b1;
    step(3);
    attack_req = 1'b0;
    step(2);
    char_class = 2'd1;
    step(10);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL scoreboard missing output: got none, expected %h", e);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
